// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard/forwarding controller: shadow EX/MEM/WB register-usage records drive
// operand forwarding selects, the load-use stall and a saturating stall-cycle counter.
module ex_hazard_controller #(
   parameter int unsigned REG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             forward_en,
   input  logic             freeze,
   input  logic             branch_taken,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   output logic [1:0]       forward1,
   output logic [1:0]       forward2,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] stall_cycles
);

   logic             r_ex_valid, r_ex_two_src, r_ex_wb_en, r_ex_mem_r_en;
   logic [REG_W-1:0] r_ex_src1, r_ex_src2, r_ex_dest;
   logic             r_mem_valid, r_mem_wb_en, r_mem_mem_r_en;
   logic [REG_W-1:0] r_mem_dest;
   logic             r_wb_valid, r_wb_wb_en;
   logic [REG_W-1:0] r_wb_dest;
   logic [CNT_W-1:0] r_stall_cycles;

   logic w_mem_fwd_ok, w_wb_fwd_ok;
   logic w_ex_wr, w_mem_wr;
   logic w_hit_ex, w_hit_mem;
   logic w_stall, w_ex_load;

   // A load result is not available in MEM, so only ALU results forward from there.
   assign w_mem_fwd_ok = r_mem_valid & r_mem_wb_en & ~r_mem_mem_r_en;
   assign w_wb_fwd_ok  = r_wb_valid & r_wb_wb_en;

   always_comb begin
      forward1 = 2'b00;
      forward2 = 2'b00;
      if (forward_en && r_ex_valid) begin
         if (w_mem_fwd_ok && (r_mem_dest == r_ex_src1)) begin
            forward1 = 2'b01;
         end else if (w_wb_fwd_ok && (r_wb_dest == r_ex_src1)) begin
            forward1 = 2'b10;
         end
         if (r_ex_two_src) begin
            if (w_mem_fwd_ok && (r_mem_dest == r_ex_src2)) begin
               forward2 = 2'b01;
            end else if (w_wb_fwd_ok && (r_wb_dest == r_ex_src2)) begin
               forward2 = 2'b10;
            end
         end
      end
   end

   assign w_ex_wr   = r_ex_valid & r_ex_wb_en;
   assign w_mem_wr  = r_mem_valid & r_mem_wb_en;
   assign w_hit_ex  = (id_src1 == r_ex_dest) | (id_two_src & (id_src2 == r_ex_dest));
   assign w_hit_mem = (id_src1 == r_mem_dest) | (id_two_src & (id_src2 == r_mem_dest));

   always_comb begin
      if (forward_en) begin
         w_stall = id_valid & w_ex_wr & r_ex_mem_r_en & w_hit_ex;
      end else begin
         w_stall = id_valid & ((w_ex_wr & w_hit_ex) | (w_mem_wr & w_hit_mem));
      end
   end

   // A taken branch kills the ID instruction, so there is nothing to stall for.
   assign hazard_stall = w_stall & ~branch_taken;
   assign w_ex_load    = id_valid & ~hazard_stall & ~branch_taken;
   assign stall_cycles = r_stall_cycles;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ex_valid     <= 1'b0;
         r_ex_src1      <= '0;
         r_ex_src2      <= '0;
         r_ex_two_src   <= 1'b0;
         r_ex_dest      <= '0;
         r_ex_wb_en     <= 1'b0;
         r_ex_mem_r_en  <= 1'b0;
         r_mem_valid    <= 1'b0;
         r_mem_dest     <= '0;
         r_mem_wb_en    <= 1'b0;
         r_mem_mem_r_en <= 1'b0;
         r_wb_valid     <= 1'b0;
         r_wb_dest      <= '0;
         r_wb_wb_en     <= 1'b0;
         r_stall_cycles <= '0;
      end else if (!freeze) begin
         r_wb_valid     <= r_mem_valid;
         r_wb_dest      <= r_mem_dest;
         r_wb_wb_en     <= r_mem_wb_en;
         r_mem_valid    <= r_ex_valid;
         r_mem_dest     <= r_ex_dest;
         r_mem_wb_en    <= r_ex_wb_en;
         r_mem_mem_r_en <= r_ex_mem_r_en;
         if (w_ex_load) begin
            r_ex_valid    <= 1'b1;
            r_ex_src1     <= id_src1;
            r_ex_src2     <= id_src2;
            r_ex_two_src  <= id_two_src;
            r_ex_dest     <= id_dest;
            r_ex_wb_en    <= id_wb_en;
            r_ex_mem_r_en <= id_mem_r_en;
         end else begin
            r_ex_valid    <= 1'b0;
            r_ex_src1     <= '0;
            r_ex_src2     <= '0;
            r_ex_two_src  <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_wb_en    <= 1'b0;
            r_ex_mem_r_en <= 1'b0;
         end
         if (hazard_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Directed bench for ex_hazard_controller; a narrow counter makes saturation reachable.
module tb_ex_hazard_controller;

   localparam int unsigned REG_W = 4;
   localparam int unsigned CNT_W = 3;

   logic             CLK = 1'b0;
   logic             RST;
   logic             forward_en, freeze, branch_taken;
   logic             id_valid, id_two_src, id_wb_en, id_mem_r_en;
   logic [REG_W-1:0] id_src1, id_src2, id_dest;
   logic [1:0]       forward1, forward2;
   logic             hazard_stall;
   logic [CNT_W-1:0] stall_cycles;

   int n_cmp = 0;
   int n_err = 0;

   ex_hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .forward_en   (forward_en),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .id_valid     (id_valid),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .id_dest      (id_dest),
      .id_wb_en     (id_wb_en),
      .id_mem_r_en  (id_mem_r_en),
      .forward1     (forward1),
      .forward2     (forward2),
      .hazard_stall (hazard_stall),
      .stall_cycles (stall_cycles)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic id(input logic v, input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                     input logic two, input logic [REG_W-1:0] d, input logic wb,
                     input logic ld);
      id_valid    = v;
      id_src1     = s1;
      id_src2     = s2;
      id_two_src  = two;
      id_dest     = d;
      id_wb_en    = wb;
      id_mem_r_en = ld;
      #1;
   endtask

   initial begin
      RST = 1'b1; forward_en = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
      id(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_f1", 16'(forward1), 16'd0);
      chk("rst_f2", 16'(forward2), 16'd0);
      chk("rst_stall", 16'(hazard_stall), 16'd0);
      chk("rst_cnt", 16'(stall_cycles), 16'd0);
      tick();
      RST = 1'b0;

      // ALU chain: ADD r1; SUB r2,r1,r1; ORR r1,r1,r5; X r1,r1,r2; Y r9,r1
      id(1, 2, 3, 1, 1, 1, 0);
      chk("alu_add_nostall", 16'(hazard_stall), 16'd0);
      tick();
      id(1, 1, 1, 1, 2, 1, 0);
      chk("alu_sub_nostall", 16'(hazard_stall), 16'd0);
      chk("alu_add_f1", 16'(forward1), 16'd0);
      tick();
      chk("alu_sub_f1", 16'(forward1), 16'd1);
      chk("alu_sub_f2", 16'(forward2), 16'd1);
      id(1, 1, 5, 1, 1, 1, 0);
      tick();
      chk("alu_orr_f1_wb", 16'(forward1), 16'd2);
      chk("alu_orr_f2", 16'(forward2), 16'd0);
      id(1, 1, 2, 1, 1, 1, 0);
      tick();
      chk("alu_x_f1_mem", 16'(forward1), 16'd1);
      chk("alu_x_f2_wb", 16'(forward2), 16'd2);
      id(1, 1, 1, 0, 9, 1, 0);
      tick();
      chk("alu_y_f1_prio", 16'(forward1), 16'd1);
      chk("alu_y_f2_gated", 16'(forward2), 16'd0);
      id(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("bubble_f1", 16'(forward1), 16'd0);

      // Load-use: LDR r4; ADD r5,r4,r6
      id(1, 8, 0, 0, 4, 1, 1);
      chk("ld_nostall", 16'(hazard_stall), 16'd0);
      tick();
      id(1, 4, 6, 1, 5, 1, 0);
      chk("ldu_stall", 16'(hazard_stall), 16'd1);
      tick();
      chk("ldu_stall_drop", 16'(hazard_stall), 16'd0);
      chk("ldu_bubble_f1", 16'(forward1), 16'd0);
      chk("ldu_cnt", 16'(stall_cycles), 16'd1);
      tick();
      id(0, 0, 0, 0, 0, 0, 0);
      chk("ldu_add_f1", 16'(forward1), 16'd2);
      chk("ldu_add_f2", 16'(forward2), 16'd0);

      // Forwarding disabled: ADD r1; ADD r2,r1,r0
      forward_en = 1'b0;
      id(1, 2, 3, 1, 1, 1, 0);
      chk("nofwd_f1_forced", 16'(forward1), 16'd0);
      chk("nofwd_a_nostall", 16'(hazard_stall), 16'd0);
      tick();
      id(1, 1, 0, 1, 2, 1, 0);
      chk("nofwd_stall_ex", 16'(hazard_stall), 16'd1);
      tick();
      chk("nofwd_stall_mem", 16'(hazard_stall), 16'd1);
      chk("nofwd_cnt_a", 16'(stall_cycles), 16'd2);
      tick();
      chk("nofwd_stall_drop", 16'(hazard_stall), 16'd0);
      chk("nofwd_cnt_b", 16'(stall_cycles), 16'd3);
      tick();
      id(0, 0, 0, 0, 0, 0, 0);
      chk("nofwd_b_f1", 16'(forward1), 16'd0);
      forward_en = 1'b1;

      // Freeze during load-use: LDR r4,[r2] behind ADD r2; then ADD r5,r4,r6
      id(1, 2, 0, 0, 4, 1, 1);
      tick();
      chk("frz_ld_f1", 16'(forward1), 16'd1);
      id(1, 4, 6, 1, 5, 1, 0);
      chk("frz_stall_pre", 16'(hazard_stall), 16'd1);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_stall_hold", 16'(hazard_stall), 16'd1);
         chk("frz_cnt_hold", 16'(stall_cycles), 16'd3);
      end
      chk("frz_f1_hold", 16'(forward1), 16'd1);
      freeze = 1'b0;
      tick();
      chk("frz_cnt_rel", 16'(stall_cycles), 16'd4);
      chk("frz_stall_drop", 16'(hazard_stall), 16'd0);
      tick();
      id(0, 0, 0, 0, 0, 0, 0);
      chk("frz_add_f1", 16'(forward1), 16'd2);

      // Branch flush with ID dependent on EX load
      id(1, 0, 0, 0, 3, 1, 1);
      tick();
      id(1, 3, 3, 1, 6, 1, 0);
      chk("fl_stall_pre", 16'(hazard_stall), 16'd1);
      branch_taken = 1'b1;
      #1;
      chk("fl_stall_killed", 16'(hazard_stall), 16'd0);
      tick();
      branch_taken = 1'b0;
      chk("fl_cnt", 16'(stall_cycles), 16'd4);
      chk("fl_f1", 16'(forward1), 16'd0);
      forward_en = 1'b0;
      id(1, 6, 6, 1, 10, 1, 0);
      chk("fl_ex_bubble", 16'(hazard_stall), 16'd0);
      forward_en = 1'b1;
      id(0, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-stream with ADD r3 in MEM
      id(1, 0, 0, 0, 3, 1, 0);
      tick();
      id(1, 3, 3, 1, 8, 1, 0);
      tick();
      chk("mrst_pre_f1", 16'(forward1), 16'd1);
      chk("mrst_pre_f2", 16'(forward2), 16'd1);
      forward_en = 1'b0;
      id(1, 8, 0, 0, 9, 1, 0);
      chk("mrst_pre_stall", 16'(hazard_stall), 16'd1);
      forward_en = 1'b1;
      RST = 1'b1;
      #1;
      chk("mrst_f1", 16'(forward1), 16'd0);
      chk("mrst_f2", 16'(forward2), 16'd0);
      chk("mrst_stall", 16'(hazard_stall), 16'd0);
      chk("mrst_cnt", 16'(stall_cycles), 16'd0);
      id(0, 0, 0, 0, 0, 0, 0);
      tick();
      RST = 1'b0;

      // Saturation: each no-forward EX dependency costs two stall cycles
      forward_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         id(1, 9, 9, 1, 1, 1, 0);
         chk("sat_a_nostall", 16'(hazard_stall), 16'd0);
         tick();
         id(1, 1, 9, 1, 2, 1, 0);
         tick();
         tick();
         tick();
         if (k == 2) chk("sat_cnt6", 16'(stall_cycles), 16'd6);
      end
      chk("sat_cnt7", 16'(stall_cycles), 16'd7);
      id(0, 0, 0, 0, 0, 0, 0);
      forward_en = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
